// File: rtl/disp_pkg.sv
// ============================================================================
// Module  : disp_pkg
// Brief   : Shared types, register map, CTRL/STAT field positions and the
//           seven-segment hex font for the display scan controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_BLANK = 2'd3
  } disp_state_t;

  localparam logic [1:0] c_ADDR_DATA_LO = 2'd0;
  localparam logic [1:0] c_ADDR_DATA_HI = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL    = 2'd2;
  localparam logic [1:0] c_ADDR_STAT    = 2'd3;

  localparam int c_CTRL_EN_BIT    = 0;
  localparam int c_CTRL_HEX_BIT   = 1;
  localparam int c_CTRL_MASK_LSB  = 8;
  localparam int c_CTRL_DWELL_LSB = 16;
  localparam int c_STAT_FRAME_BIT = 8;

  // Segment order {dp,g,f,e,d,c,b,a}; dp is supplied separately.
  localparam logic [7:0] c_HEX_FONT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be_v
  );
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (be_v[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_hex_dec.sv
// ============================================================================
// Module  : seg_hex_dec
// Brief   : Combinational nibble-to-seven-segment decoder with decimal point.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_hex_dec
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_font;

  always_comb begin
    w_font = c_HEX_FONT[i_nibble];
    o_seg  = {i_dp, w_font[6:0]};
  end

endmodule

`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
// ============================================================================
// Module  : disp_scan_ctrl
// Brief   : Eight-digit multiplexed display scanner with a 4-register bus.
//           Optional hex decoding is enabled by defining DISP_HEX_DECODE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int          BLANK_CYC = 64,
  parameter logic [15:0] DWELL_RST = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  A,
  input  logic [31:0] D,
  input  logic [3:0]  be,
  output logic [31:0] Dout,
  output logic [7:0]  seg,
  output logic [7:0]  select
);

  localparam int             c_BLK_W    = $clog2(BLANK_CYC + 1);
  localparam logic [c_BLK_W-1:0] c_BLK_LOAD = c_BLK_W'(BLANK_CYC - 1);

  logic [31:0]        r_data_lo;
  logic [31:0]        r_data_hi;
  logic               r_en;
  logic [7:0]         r_mask;
  logic [15:0]        r_dwell;
  disp_state_t        r_state;
  logic [2:0]         r_idx;
  logic               r_frame;
  logic [15:0]        r_dwell_cnt;
  logic [c_BLK_W-1:0] r_blk_cnt;
  logic [7:0]         r_seg;
  logic [7:0]         r_sel;

  logic               w_wr_lo;
  logic               w_wr_hi;
  logic               w_wr_ctrl;
  logic               w_frame_clr;
  logic               w_en_nxt;
  logic [7:0]         w_mask_nxt;
  logic               w_run_nxt;
  logic               w_hex_rd;
  logic [63:0]        w_data_all;
  logic [7:0]         w_raw_pat;
  logic [7:0]         w_pat;
  logic [31:0]        w_ctrl_rd;
  logic [31:0]        w_stat_rd;

  assign w_wr_lo     = we && (A == c_ADDR_DATA_LO);
  assign w_wr_hi     = we && (A == c_ADDR_DATA_HI);
  assign w_wr_ctrl   = we && (A == c_ADDR_CTRL);
  assign w_frame_clr = we && (A == c_ADDR_STAT) && be[1] && D[c_STAT_FRAME_BIT];

  // Run decision uses the post-write CTRL so a disabling write idles next cycle.
  assign w_en_nxt   = (w_wr_ctrl && be[0]) ? D[c_CTRL_EN_BIT] : r_en;
  assign w_mask_nxt = (w_wr_ctrl && be[1]) ? D[c_CTRL_MASK_LSB +: 8] : r_mask;
  assign w_run_nxt  = w_en_nxt && (w_mask_nxt != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_lo <= 32'd0;
      r_data_hi <= 32'd0;
      r_en      <= 1'b1;
      r_mask    <= 8'hFF;
      r_dwell   <= DWELL_RST;
    end else begin
      if (w_wr_lo) r_data_lo <= merge_bytes(r_data_lo, D, be);
      if (w_wr_hi) r_data_hi <= merge_bytes(r_data_hi, D, be);
      r_en   <= w_en_nxt;
      r_mask <= w_mask_nxt;
      if (w_wr_ctrl && be[2]) r_dwell[7:0]  <= D[c_CTRL_DWELL_LSB +: 8];
      if (w_wr_ctrl && be[3]) r_dwell[15:8] <= D[c_CTRL_DWELL_LSB + 8 +: 8];
    end
  end

  assign w_data_all = {r_data_hi, r_data_lo};
  assign w_raw_pat  = w_data_all[{r_idx, 3'b000} +: 8];

`ifdef DISP_HEX_DECODE_EN
  logic       r_hex;
  logic [3:0] w_nibble;
  logic       w_dp;
  logic [7:0] w_hex_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= 1'b0;
    end else if (w_wr_ctrl && be[0]) begin
      r_hex <= D[c_CTRL_HEX_BIT];
    end
  end

  assign w_nibble = r_data_lo[{r_idx, 2'b00} +: 4];
  assign w_dp     = r_data_hi[r_idx];

  seg_hex_dec u_hex_dec (
    .i_nibble (w_nibble),
    .i_dp     (w_dp),
    .o_seg    (w_hex_pat)
  );

  assign w_hex_rd = r_hex;
  assign w_pat    = r_hex ? w_hex_pat : w_raw_pat;
`else
  assign w_hex_rd = 1'b0;
  assign w_pat    = w_raw_pat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_frame     <= 1'b0;
      r_dwell_cnt <= 16'd0;
      r_blk_cnt   <= '0;
      r_seg       <= 8'd0;
      r_sel       <= 8'd0;
    end else begin
      // A wrap in the same cycle overrides the clear below.
      if (w_frame_clr) r_frame <= 1'b0;
      if (!w_run_nxt) begin
        r_state     <= ST_IDLE;
        r_idx       <= 3'd0;
        r_dwell_cnt <= 16'd0;
        r_blk_cnt   <= '0;
        r_seg       <= 8'd0;
        r_sel       <= 8'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (r_mask[r_idx]) begin
              r_seg       <= w_pat;
              r_sel       <= 8'h80 >> r_idx;
              r_dwell_cnt <= (r_dwell == 16'd0) ? 16'd0 : r_dwell - 16'd1;
              r_state     <= ST_SHOW;
            end else begin
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_frame <= 1'b1;
            end
          end
          ST_SHOW: begin
            if (r_dwell_cnt == 16'd0) begin
              r_seg     <= 8'd0;
              r_sel     <= 8'd0;
              r_blk_cnt <= c_BLK_LOAD;
              r_state   <= ST_BLANK;
            end else begin
              r_dwell_cnt <= r_dwell_cnt - 16'd1;
            end
          end
          ST_BLANK: begin
            if (r_blk_cnt == '0) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_LOAD;
              if (r_idx == 3'd7) r_frame <= 1'b1;
            end else begin
              r_blk_cnt <= r_blk_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_ctrl_rd = {r_dwell, r_mask, 6'd0, w_hex_rd, r_en};
  assign w_stat_rd = {23'd0, r_frame, 2'd0, r_state, 1'b0, r_idx};

  // Reads come straight from the registers, so a same-cycle write is not visible.
  always_comb begin
    Dout = 32'd0;
    case (A)
      c_ADDR_DATA_LO: Dout = r_data_lo;
      c_ADDR_DATA_HI: Dout = r_data_hi;
      c_ADDR_CTRL:    Dout = w_ctrl_rd;
      c_ADDR_STAT:    Dout = w_stat_rd;
      default:        Dout = 32'd0;
    endcase
  end

  assign seg    = r_seg;
  assign select = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// ============================================================================
// Module  : tb_disp_scan_ctrl
// Brief   : Self-checking bench for disp_scan_ctrl against a digit-sequence
//           reference model. Hex checks are included when DISP_HEX_DECODE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_disp_scan_ctrl;

  localparam int BLK = 4;
`ifdef DISP_HEX_DECODE_EN
  localparam logic [31:0] CTRL_RD = 32'hFFFF_FF03;
`else
  localparam logic [31:0] CTRL_RD = 32'hFFFF_FF01;
`endif
  localparam logic [7:0] FONT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  A     = 2'd3;
  logic [31:0] D     = 32'd0;
  logic [3:0]  be    = 4'd0;
  logic [31:0] Dout;
  logic [7:0]  seg;
  logic [7:0]  select;

  int n_chk  = 0;
  int n_fail = 0;

  disp_scan_ctrl #(
    .BLANK_CYC (BLK),
    .DWELL_RST (16'h0100)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .A      (A),
    .D      (D),
    .be     (be),
    .Dout   (Dout),
    .seg    (seg),
    .select (select)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]  e_seg [$];
  logic [7:0]  e_sel [$];
  logic [31:0] e_stat[$];
  logic [31:0] m_lo, m_hi, m_ctrl, m_wd;
  logic [1:0]  m_wa;
  logic [3:0]  m_wbe;
  bit          m_hw;
  int          m_w;
  int          m_idx;
  bit          m_frame, m_wrap;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Register value as seen during cycle c of the run.
  function automatic logic [31:0] reg_at(input int a, input int c);
    logic [31:0] v;
    v = (a == 0) ? m_lo : (a == 1) ? m_hi : m_ctrl;
    if (m_hw && int'(m_wa) == a && a != 3 && c >= m_w + 1) begin
      v = merge(v, m_wd, m_wbe);
      if (a == 2) v = v & CTRL_RD;
    end
    return v;
  endfunction

  function automatic logic [7:0] pat_at(input int i, input int c);
    logic [31:0] lo, hi, ct;
    lo = reg_at(0, c);
    hi = reg_at(1, c);
    ct = reg_at(2, c);
    if (ct[1]) return {hi[i], FONT[lo[4*i +: 4]][6:0]};
    return (i < 4) ? lo[8*i +: 8] : hi[8*(i-4) +: 8];
  endfunction

  task automatic m_push(input logic [7:0] s, input logic [7:0] sl, input logic [1:0] st);
    int c;
    c = e_seg.size();
    if (m_hw && m_wa == 2'd3 && c == m_w + 1 && m_wbe[1] && m_wd[8]) m_frame = 1'b0;
    if (m_wrap) begin
      m_frame = 1'b1;
      m_wrap  = 1'b0;
    end
    e_seg.push_back(s);
    e_sel.push_back(sl);
    e_stat.push_back({23'd0, m_frame, 2'd0, st, 1'b0, m_idx[2:0]});
  endtask

  task automatic m_adv();
    m_idx = (m_idx + 1) % 8;
    if (m_idx == 0) m_wrap = 1'b1;
  endtask

  // Cycle 0 is the first LOAD cycle after the enabling CTRL write.
  task automatic build_model(input int n);
    e_seg.delete(); e_sel.delete(); e_stat.delete();
    m_idx = 0; m_frame = 1'b0; m_wrap = 1'b0;
    while (e_seg.size() < n) begin
      logic [31:0] ct;
      logic [7:0]  p;
      int          dw;
      ct = reg_at(2, e_seg.size());
      while (!ct[8 + m_idx]) begin
        m_push(8'd0, 8'd0, 2'd1);
        m_adv();
        ct = reg_at(2, e_seg.size());
      end
      p  = pat_at(m_idx, e_seg.size());
      dw = int'(ct[31:16]);
      if (dw == 0) dw = 1;
      m_push(8'd0, 8'd0, 2'd1);
      repeat (dw) m_push(p, 8'h80 >> m_idx, 2'd2);
      repeat (BLK) m_push(8'd0, 8'd0, 2'd3);
      m_adv();
    end
  endtask

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; A = a; D = d; be = b;
    @(negedge clk);
    we = 1'b0; A = 2'd3; be = 4'd0;
  endtask

  task automatic start_run(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] ctrl);
    bus_write(2'd2, 32'd0, 4'hF);
    bus_write(2'd0, lo, 4'hF);
    bus_write(2'd1, hi, 4'hF);
    bus_write(2'd3, 32'h100, 4'h2);
    bus_write(2'd2, ctrl, 4'hF);
  endtask

  task automatic run_scn(input string name, input logic [31:0] lo, input logic [31:0] hi,
                         input logic [31:0] ctrl, input int n, input bit hw, input int w,
                         input logic [1:0] wa, input logic [31:0] wd, input logic [3:0] wbe);
    logic [31:0] exp;
    m_lo = lo; m_hi = hi; m_ctrl = ctrl & CTRL_RD;
    m_hw = hw; m_w = w; m_wa = wa; m_wd = wd; m_wbe = wbe;
    build_model(n);
    start_run(lo, hi, ctrl);
    for (int c = 0; c < n; c++) begin
      if (hw && c == w) begin
        we = 1'b1; A = wa; D = wd; be = wbe;
      end else begin
        we = 1'b0; A = 2'd3; be = 4'd0;
      end
      #1;
      n_chk++;
      if (seg !== e_seg[c] || select !== e_sel[c]) begin
        n_fail++;
        $display("FAIL %s cyc%0d seg/select: got %h/%h expected %h/%h",
                 name, c, seg, select, e_seg[c], e_sel[c]);
      end
      if (hw && c == w) exp = (wa == 2'd3) ? e_stat[c] : reg_at(int'(wa), c);
      else              exp = e_stat[c];
      n_chk++;
      if (Dout !== exp) begin
        n_fail++;
        $display("FAIL %s cyc%0d Dout(A=%0d): got %h expected %h", name, c, A, Dout, exp);
      end
      @(negedge clk);
    end
    we = 1'b0; A = 2'd3; be = 4'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'd0, 32'd0, 32'h0100FF01, 32'd0};
    @(negedge clk); @(negedge clk);
    n_chk++;
    if (seg !== 8'd0 || select !== 8'd0) begin
      n_fail++;
      $display("FAIL reset seg/select: got %h/%h expected 00/00", seg, select);
    end
    for (int a = 0; a < 4; a++) begin
      A = a[1:0];
      #1;
      n_chk++;
      if (Dout !== exp_rd[a]) begin
        n_fail++;
        $display("FAIL reset reg%0d: got %h expected %h", a, Dout, exp_rd[a]);
      end
    end
    A = 2'd3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] xs [10];
    logic [7:0] xl [10];
    xs = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22};
    xl = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    start_run(32'h44332211, 32'd0, {16'd3, 8'hFF, 8'h01});
    for (int c = 0; c < 10; c++) begin
      #1;
      n_chk++;
      if (seg !== xs[c] || select !== xl[c]) begin
        n_fail++;
        $display("FAIL basic cyc%0d: got %h/%h expected %h/%h", c, seg, select, xs[c], xl[c]);
      end
      @(negedge clk);
    end
    run_scn("basic_model", 32'h44332211, 32'h88776655, {16'd3, 8'hFF, 8'h01}, 100, 1'b0, -5, 2'd0, 32'd0, 4'd0);
  endtask

  task automatic test_mask();
    run_scn("mask05", 32'h44332211, 32'h88776655, {16'd2, 8'h05, 8'h01}, 60, 1'b0, -5, 2'd0, 32'd0, 4'd0);
  endtask

  task automatic test_glitch();
    run_scn("glitch", 32'h44332211, 32'd0, {16'd5, 8'h01, 8'h01}, 40, 1'b1, 3, 2'd0, 32'hAA, 4'b0001);
    A = 2'd0;
    #1;
    n_chk++;
    if (Dout !== 32'h443322AA) begin
      n_fail++;
      $display("FAIL glitch DATA_LO: got %h expected 443322aa", Dout);
    end
    A = 2'd3;
  endtask

  task automatic test_dwell_change();
    run_scn("dwell", 32'h0C0B0A09, 32'h100F0E0D, {16'd2, 8'hFF, 8'h01}, 60, 1'b1, 1, 2'd2, 32'h0005_0000, 4'b1100);
  endtask

  task automatic test_en_clear();
    start_run(32'h44332211, 32'd0, {16'd4, 8'hFF, 8'h01});
    @(negedge clk); @(negedge clk);
    #1;
    n_chk++;
    if (select !== 8'h80 || seg !== 8'h11) begin
      n_fail++;
      $display("FAIL en_clear pre: got %h/%h expected 11/80", seg, select);
    end
    we = 1'b1; A = 2'd2; D = {16'd4, 8'hFF, 8'h00}; be = 4'hF;
    @(negedge clk);
    we = 1'b0; A = 2'd3; be = 4'd0;
    #1;
    n_chk++;
    if (seg !== 8'd0 || select !== 8'd0 || Dout[5:0] !== 6'd0) begin
      n_fail++;
      $display("FAIL en_clear post: got seg %h sel %h stat %h expected 00 00 idle/idx0", seg, select, Dout[5:0]);
    end
    start_run(32'h44332211, 32'd0, {16'd2, 8'hFF, 8'h01});
    repeat (9) @(negedge clk);
    #1;
    n_chk++;
    if (select !== 8'h40 || seg !== 8'h22) begin
      n_fail++;
      $display("FAIL mask_zero pre: got %h/%h expected 22/40", seg, select);
    end
    we = 1'b1; A = 2'd2; D = 32'd0; be = 4'b0010;
    @(negedge clk);
    we = 1'b0; A = 2'd3; be = 4'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++;
      if (seg !== 8'd0 || select !== 8'd0 || Dout[5:0] !== 6'd0) begin
        n_fail++;
        $display("FAIL mask_zero cyc%0d: got seg %h sel %h stat %h expected 00 00 00", k, seg, select, Dout[5:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_w1c();
    int cw;
    m_lo = 32'h04030201; m_hi = 32'h08070605; m_ctrl = {16'd1, 8'h81, 8'h01};
    m_hw = 1'b0; m_w = -5;
    build_model(80);
    cw = -1;
    for (int c = 0; c < 80; c++) if (cw < 0 && e_stat[c][8]) cw = c;
    n_chk++;
    if (cw < 1) begin
      n_fail++;
      $display("FAIL frame setup: no wrap found in model, got %0d required >=1", cw);
    end else begin
      run_scn("w1c_wrap", 32'h04030201, 32'h08070605, {16'd1, 8'h81, 8'h01}, 80, 1'b1, cw - 1, 2'd3, 32'h100, 4'b0010);
      run_scn("w1c_norm", 32'h04030201, 32'h08070605, {16'd1, 8'h81, 8'h01}, 80, 1'b1, cw + 2, 2'd3, 32'h100, 4'b0010);
      run_scn("w1c_nobe", 32'h04030201, 32'h08070605, {16'd1, 8'h81, 8'h01}, 80, 1'b1, cw + 2, 2'd3, 32'h100, 4'b1101);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] lo, hi, wd;
      logic [7:0]  mk;
      logic [15:0] dw;
      logic [1:0]  wa;
      logic [3:0]  wbe;
      int          n, w, tmp;
      lo  = $urandom;
      hi  = $urandom;
      tmp = $urandom_range(1, 255); mk = tmp[7:0];
      tmp = $urandom_range(0, 5);   dw = tmp[15:0];
      n   = $urandom_range(40, 120);
      w   = $urandom_range(0, n - 2);
      tmp = $urandom_range(0, 3);   wa = tmp[1:0];
      if (wa == 2'd2) begin
        wd  = 32'($urandom_range(0, 5)) << 16;
        wbe = 4'b1100;
      end else begin
        wd  = $urandom;
        tmp = $urandom_range(0, 15); wbe = tmp[3:0];
      end
      run_scn("random", lo, hi, {dw, mk, 8'h01}, n, 1'b1, w, wa, wd, wbe);
    end
  endtask

  task automatic test_async_reset();
    start_run(32'h44332211, 32'd0, {16'd5, 8'hFF, 8'h01});
    @(negedge clk); @(negedge clk);
    #1;
    n_chk++;
    if (select !== 8'h80 || seg !== 8'h11) begin
      n_fail++;
      $display("FAIL async_reset pre: got %h/%h expected 11/80", seg, select);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (seg !== 8'd0 || select !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h expected 00/00", seg, select);
    end
    @(negedge clk);
    A = 2'd0;
    #1;
    n_chk++;
    if (Dout !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset DATA_LO: got %h expected 00000000", Dout);
    end
    A = 2'd3;
    rst_n = 1'b1;
  endtask

`ifdef DISP_HEX_DECODE_EN
  task automatic test_hex();
    start_run(32'h0000000F, 32'h00000001, {16'd3, 8'h01, 8'h03});
    @(negedge clk);
    #1;
    n_chk++;
    if (seg !== 8'hF1 || select !== 8'h80) begin
      n_fail++;
      $display("FAIL hex digit0: got %h/%h expected f1/80", seg, select);
    end
    @(negedge clk);
    run_scn("hex_model", 32'h89ABCDEF, 32'h000000A5, {16'd2, 8'hFF, 8'h03}, 90, 1'b0, -5, 2'd0, 32'd0, 4'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_glitch();
    test_dwell_change();
    test_en_clear();
    test_frame_w1c();
    test_random();
`ifdef DISP_HEX_DECODE_EN
    test_hex();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL take parameter BLANK_CYC, default 64, meaning inter-digit blanking cycles (min 1).
REQ-002 SHALL take parameter DWELL_RST, default 16'h0100, meaning reset dwell cycles per digit.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port we  in  1  bus write strobe.
REQ-006 SHALL have port A  in  2  register select: 0 DATA_LO, 1 DATA_HI, 2 CTRL, 3 STAT.
REQ-007 SHALL have port D  in  32  write data.
REQ-008 SHALL have port be  in  4  byte enables, any combination honoured per byte.
REQ-009 SHALL have port Dout  out  32  combinational read of register at A.
REQ-010 SHALL have port seg  out  8  segment pattern, active high, bit7 = decimal point.
REQ-011 SHALL have port select  out  8  one-hot digit strobe, digit i = 8'h80>>i, 0 when blank.

Function
REQ-012 CTRL SHALL hold: bit0 EN, bit1 HEX, bits[15:8] digit MASK, bits[31:16] DWELL.
REQ-013 STAT SHALL hold: bits[2:0] current digit index, bits[5:4] state, bit8 FRAME sticky (write-1-to-clear via be[1]); other bits read 0 and ignore writes.
REQ-014 FSM states SHALL be IDLE(0), LOAD(1), SHOW(2), BLANK(3).
REQ-015 IDLE: seg=0, select=0; leave to LOAD when EN=1 and MASK!=0.
REQ-016 LOAD (1 cycle): latch pattern for current index, seg/select stay 0; if index is masked, advance index instead and remain in LOAD.
REQ-017 SHOW: drive latched seg and select for exactly max(DWELL,1) cycles, then BLANK.
REQ-018 BLANK: seg=0, select=0 for BLANK_CYC cycles, then advance index (7 wraps to 0) and enter LOAD.
REQ-019 FRAME SHALL set on the 7->0 wrap; a simultaneous set and W1C SHALL leave FRAME=1.
REQ-020 Raw mode (HEX=0): digit i pattern = byte (i mod 4) of DATA_LO (i<4) or DATA_HI (i>=4).
REQ-021 DATA writes during SHOW SHALL NOT change seg until the next LOAD (no mid-digit glitch).
REQ-022 EN cleared or MASK written 0 in any state SHALL force IDLE next cycle with seg=select=0 and index=0.
REQ-023 CTRL writes to DWELL during SHOW SHALL take effect at the next SHOW.
REQ-024 seg and select SHALL never be nonzero in the same cycle for two different digits; select is 0 for at least BLANK_CYC cycles between digits.
REQ-025 Dout for a register written this cycle SHALL return the pre-write value.

Reset
REQ-026 On rst_n low: DATA_LO=DATA_HI=0, CTRL={DWELL_RST,8'hFF,6'b0,HEX=0,EN=1}, STAT=0, state IDLE, seg=0, select=0, counters 0.
REQ-027 Reset asserted mid-SHOW SHALL clear seg/select immediately (asynchronously).

Configuration
REQ-028 Macro DISP_HEX_DECODE_EN defined: HEX=1 maps digit i to nibble i of DATA_LO via 16-entry font, DP = DATA_HI bit i into seg[7].
REQ-029 Macro undefined: CTRL bit1 reads 0, ignores writes, raw mode only; no decoder instantiated.

Structure
REQ-030 Package disp_pkg SHALL hold the state enum, register address constants, CTRL field positions, and the hex font table.
REQ-031 Sub-module seg_hex_dec (4-bit nibble + dp in, 8-bit pattern out, combinational) SHALL be used only under DISP_HEX_DECODE_EN.
REQ-032 Counters: dwell counter 16 bits, blank counter clog2(BLANK_CYC+1) bits, index 3 bits.

Verification
REQ-033 Reset, write DATA_LO=32'h44332211 be=4'hF, BLANK_CYC=4, DWELL=3 -> digit0 shows seg=8'h11 select=8'h80 for 3 cycles, then 4 blank cycles, digit1 seg=8'h22 select=8'h40.
REQ-034 MASK=8'b0000_0101 -> only select 8'h80 and 8'h20 ever asserted, alternating; FRAME sets after digit2 wraps.
REQ-035 Write DATA_LO byte 0 (be=4'b0001, D=32'hAA) mid-SHOW of digit0 -> seg unchanged until digit0's next LOAD, then 8'hAA; bytes 1-3 unchanged.
REQ-036 Write CTRL EN=0 mid-SHOW -> next cycle seg=0, select=0, STAT[5:4]=0, index 0.
REQ-037 With DISP_HEX_DECODE_EN, HEX=1, DATA_LO=32'h0000000F, DATA_HI bit0=1 -> digit0 seg=font(F)|8'h80.
REQ-038 FRAME=1, write STAT D=32'h100 be=4'b0010 on a non-wrap cycle -> FRAME reads 0; on a wrap cycle -> stays 1.
